// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: hardwired T0..T6 control-step sequencer for R-type ALU
// instructions on a single-bus datapath. Fetch stalls on mem_ready, MUL/DIV
// take an extra HI writeback step. All outputs come straight from flops.
// Optional build macro: ALU_SEQ_R0_ZERO_EN (R0 becomes read-only).
module alu_op_sequencer #(
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          REG_ADDR_W = 4,
    parameter int unsigned          OPCODE_W   = 5,
    parameter logic [OPCODE_W-1:0]  MUL_OP     = 5'b01111,
    parameter logic [OPCODE_W-1:0]  DIV_OP     = 5'b10000
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         start,
    input  logic                         mem_ready,
    input  logic [DATA_W-1:0]            bus_in,
    output logic                         PCout,
    output logic                         MARin,
    output logic                         incPC,
    output logic                         Zin,
    output logic                         ZLowOut,
    output logic                         ZHighOut,
    output logic                         PCin,
    output logic                         read,
    output logic                         MDRin,
    output logic                         MDRout,
    output logic                         IRin,
    output logic                         Yin,
    output logic                         HIin,
    output logic                         LOin,
    output logic [(2**REG_ADDR_W)-1:0]   reg_in,
    output logic [(2**REG_ADDR_W)-1:0]   reg_out,
    output logic [OPCODE_W-1:0]          alu_op,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned NUM_REGS = 2**REG_ADDR_W;
    // Only opcode + three register fields are kept; the low bus bits are don't-care
    localparam int unsigned IR_W     = OPCODE_W + 3*REG_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_t;

    typedef struct packed {
        logic                pc_out;
        logic                mar_in;
        logic                inc_pc;
        logic                z_in;
        logic                z_low_out;
        logic                z_high_out;
        logic                pc_in;
        logic                rd;
        logic                mdr_in;
        logic                mdr_out;
        logic                ir_in;
        logic                y_in;
        logic                hi_in;
        logic                lo_in;
        logic [NUM_REGS-1:0] r_in;
        logic [NUM_REGS-1:0] r_out;
        logic [OPCODE_W-1:0] op;
        logic                bsy;
        logic                dne;
    } ctl_t;

    state_t            state;
    state_t            nxt_state;
    logic [IR_W-1:0]   ir;
    logic [IR_W-1:0]   nxt_ir;
    ctl_t              ctl_q;
    logic              is_muldiv_c;
    logic              unused_bus_low;

    assign unused_bus_low = ^bus_in[DATA_W-IR_W-1:0];

    // Output decode for one (state, instruction) pair; registered by the caller
    function automatic ctl_t decode(input state_t s, input logic [IR_W-1:0] instr);
        ctl_t                  c;
        logic [OPCODE_W-1:0]   opc;
        logic [REG_ADDR_W-1:0] ra;
        logic [REG_ADDR_W-1:0] rb;
        logic [REG_ADDR_W-1:0] rc;
        logic [NUM_REGS-1:0]   one;
        c   = '0;
        opc = instr[IR_W-1 -: OPCODE_W];
        ra  = instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
        rb  = instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
        rc  = instr[REG_ADDR_W-1:0];
        one = NUM_REGS'(1);
        c.bsy = (s != S_IDLE);
        case (s)
            S_T0: begin
                c.pc_out = 1'b1;
                c.mar_in = 1'b1;
                c.inc_pc = 1'b1;
                c.z_in   = 1'b1;
            end
            S_T1: begin
                c.z_low_out = 1'b1;
                c.pc_in     = 1'b1;
                c.rd        = 1'b1;
                c.mdr_in    = 1'b1;
            end
            S_T2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
            end
            S_T3: begin
                c.r_out = one << rb;
                c.y_in  = 1'b1;
            end
            S_T4: begin
                c.r_out = one << rc;
                c.z_in  = 1'b1;
                c.op    = opc;
            end
            S_T5: begin
                c.z_low_out = 1'b1;
                if (opc == MUL_OP || opc == DIV_OP) begin
                    c.lo_in = 1'b1;
                end else begin
                    c.r_in = one << ra;
`ifdef ALU_SEQ_R0_ZERO_EN
                    c.r_in[0] = 1'b0;
`endif
                    c.dne  = 1'b1;
                end
            end
            S_T6: begin
                c.z_high_out = 1'b1;
                c.hi_in      = 1'b1;
                c.dne        = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign is_muldiv_c = (ir[IR_W-1 -: OPCODE_W] == MUL_OP) ||
                         (ir[IR_W-1 -: OPCODE_W] == DIV_OP);

    // Next-state and instruction-latch logic; instruction is zeroed whenever IDLE
    always_comb begin
        nxt_state = state;
        nxt_ir    = ir;
        case (state)
            S_IDLE: if (start) nxt_state = S_T0;
            S_T0:   nxt_state = S_T1;
            S_T1:   if (mem_ready) nxt_state = S_T2;
            S_T2: begin
                nxt_state = S_T3;
                nxt_ir    = bus_in[DATA_W-1 -: IR_W];
            end
            S_T3:   nxt_state = S_T4;
            S_T4:   nxt_state = S_T5;
            S_T5:   nxt_state = is_muldiv_c ? S_T6 : S_IDLE;
            S_T6:   nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
        if (nxt_state == S_IDLE) begin
            nxt_ir = '0;
        end
    end

    // State, instruction and output registers; clear drops everything to IDLE at once
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
            ir    <= '0;
            ctl_q <= '0;
        end else begin
            state <= nxt_state;
            ir    <= nxt_ir;
            ctl_q <= decode(nxt_state, nxt_ir);
        end
    end

    assign PCout    = ctl_q.pc_out;
    assign MARin    = ctl_q.mar_in;
    assign incPC    = ctl_q.inc_pc;
    assign Zin      = ctl_q.z_in;
    assign ZLowOut  = ctl_q.z_low_out;
    assign ZHighOut = ctl_q.z_high_out;
    assign PCin     = ctl_q.pc_in;
    assign read     = ctl_q.rd;
    assign MDRin    = ctl_q.mdr_in;
    assign MDRout   = ctl_q.mdr_out;
    assign IRin     = ctl_q.ir_in;
    assign Yin      = ctl_q.y_in;
    assign HIin     = ctl_q.hi_in;
    assign LOin     = ctl_q.lo_in;
    assign reg_in   = ctl_q.r_in;
    assign reg_out  = ctl_q.r_out;
    assign alu_op   = ctl_q.op;
    assign busy     = ctl_q.bsy;
    assign done     = ctl_q.dne;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: per-step strobe/select checks for
// ADD, SUB with fetch stall, MUL, DIV, clear mid-op, start handling and R0.
module tb_alu_op_sequencer;

    logic        clock;
    logic        clear;
    logic        start;
    logic        mem_ready;
    logic [31:0] bus_in;
    logic        PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, read;
    logic        MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic [4:0]  alu_op;
    logic        busy;
    logic        done;
    logic [13:0] strb;

    int total;
    int bad;
    int steps;

    localparam logic [13:0] B_PCOUT  = 14'h2000;
    localparam logic [13:0] B_MARIN  = 14'h1000;
    localparam logic [13:0] B_INCPC  = 14'h0800;
    localparam logic [13:0] B_ZIN    = 14'h0400;
    localparam logic [13:0] B_ZLOW   = 14'h0200;
    localparam logic [13:0] B_ZHIGH  = 14'h0100;
    localparam logic [13:0] B_PCIN   = 14'h0080;
    localparam logic [13:0] B_READ   = 14'h0040;
    localparam logic [13:0] B_MDRIN  = 14'h0020;
    localparam logic [13:0] B_MDROUT = 14'h0010;
    localparam logic [13:0] B_IRIN   = 14'h0008;
    localparam logic [13:0] B_YIN    = 14'h0004;
    localparam logic [13:0] B_HIIN   = 14'h0002;
    localparam logic [13:0] B_LOIN   = 14'h0001;

    localparam logic [13:0] S0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [13:0] S1  = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
    localparam logic [13:0] S2  = B_MDROUT | B_IRIN;
    localparam logic [13:0] S3  = B_YIN;
    localparam logic [13:0] S4  = B_ZIN;
    localparam logic [13:0] S5  = B_ZLOW;
    localparam logic [13:0] S5M = B_ZLOW | B_LOIN;
    localparam logic [13:0] S6  = B_ZHIGH | B_HIIN;

`ifdef ALU_SEQ_R0_ZERO_EN
    localparam logic [15:0] R0_WR = 16'h0000;
`else
    localparam logic [15:0] R0_WR = 16'h0001;
`endif

    alu_op_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .mem_ready (mem_ready),
        .bus_in    (bus_in),
        .PCout     (PCout),
        .MARin     (MARin),
        .incPC     (incPC),
        .Zin       (Zin),
        .ZLowOut   (ZLowOut),
        .ZHighOut  (ZHighOut),
        .PCin      (PCin),
        .read      (read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .HIin      (HIin),
        .LOin      (LOin),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .alu_op    (alu_op),
        .busy      (busy),
        .done      (done)
    );

    assign strb = {PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, read,
                   MDRin, MDRout, IRin, Yin, HIin, LOin};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [13:0] e_strb,
                              input logic [15:0] e_rin, input logic [15:0] e_rout,
                              input logic [4:0] e_op, input logic e_busy, input logic e_done);
        check({tag, ".strb"}, 32'(strb),    32'(e_strb));
        check({tag, ".rin"},  32'(reg_in),  32'(e_rin));
        check({tag, ".rout"}, 32'(reg_out), 32'(e_rout));
        check({tag, ".op"},   32'(alu_op),  32'(e_op));
        check({tag, ".busy"}, 32'(busy),    32'(e_busy));
        check({tag, ".done"}, 32'(done),    32'(e_done));
    endtask

    // Advance one clock and compare the outputs just after the edge
    task automatic exp_step(input string tag, input logic [13:0] e_strb,
                            input logic [15:0] e_rin, input logic [15:0] e_rout,
                            input logic [4:0] e_op, input logic e_busy, input logic e_done);
        @(posedge clock);
        #1;
        steps++;
        check_outs(tag, e_strb, e_rin, e_rout, e_op, e_busy, e_done);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    initial begin
        total     = 0;
        bad       = 0;
        steps     = 0;
        clear     = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b1;
        bus_in    = 32'd0;

        // Reset state
        #3;
        check_outs("rst", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        clear = 1'b1;
        exp_step("idle0", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

        // ADD r7 <- r4 + r3
        bus_in = mk(5'b00011, 4'd7, 4'd4, 4'd3);
        start  = 1'b1;
        exp_step("add.t0", S0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        start  = 1'b0;
        exp_step("add.t1", S1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("add.t2", S2, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("add.t3", S3, 16'h0000, 16'h0010, 5'd0, 1'b1, 1'b0);
        exp_step("add.t4", S4, 16'h0000, 16'h0008, 5'd3, 1'b1, 1'b0);
        exp_step("add.t5", S5, 16'h0080, 16'h0000, 5'd0, 1'b1, 1'b1);
        exp_step("add.end", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

        // SUB r2 <- r5 - r9 with mem_ready low for 3 cycles in T1
        bus_in    = mk(5'b00100, 4'd2, 4'd5, 4'd9);
        mem_ready = 1'b0;
        start     = 1'b1;
        steps     = 0;
        exp_step("stl.t0", S0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        start     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_step($sformatf("stl.t1_%0d", i), S1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        end
        mem_ready = 1'b1;
        exp_step("stl.t2", S2, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("stl.t3", S3, 16'h0000, 16'h0020, 5'd0, 1'b1, 1'b0);
        exp_step("stl.t4", S4, 16'h0000, 16'h0200, 5'd4, 1'b1, 1'b0);
        exp_step("stl.t5", S5, 16'h0004, 16'h0000, 5'd0, 1'b1, 1'b1);
        check("stl.latency", 32'(steps), 32'd9);
        exp_step("stl.end", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

        // MUL r1 <- r2 * r3: LO then HI writeback
        bus_in = mk(5'b01111, 4'd1, 4'd2, 4'd3);
        start  = 1'b1;
        exp_step("mul.t0", S0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        start  = 1'b0;
        exp_step("mul.t1", S1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("mul.t2", S2, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("mul.t3", S3, 16'h0000, 16'h0004, 5'd0, 1'b1, 1'b0);
        exp_step("mul.t4", S4, 16'h0000, 16'h0008, 5'h0F, 1'b1, 1'b0);
        exp_step("mul.t5", S5M, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("mul.t6", S6, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b1);
        exp_step("mul.end", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

        // DIV r15 <- r0 / r15: boundary register indices
        bus_in = mk(5'b10000, 4'd15, 4'd0, 4'd15);
        start  = 1'b1;
        exp_step("div.t0", S0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        start  = 1'b0;
        exp_step("div.t1", S1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("div.t2", S2, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("div.t3", S3, 16'h0000, 16'h0001, 5'd0, 1'b1, 1'b0);
        exp_step("div.t4", S4, 16'h0000, 16'h8000, 5'h10, 1'b1, 1'b0);
        exp_step("div.t5", S5M, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("div.t6", S6, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b1);
        exp_step("div.end", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

        // clear during T4: outputs drop before the next edge, no writeback afterwards
        bus_in = mk(5'b00011, 4'd6, 4'd1, 4'd2);
        start  = 1'b1;
        exp_step("clr.t0", S0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        start  = 1'b0;
        exp_step("clr.t1", S1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("clr.t2", S2, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("clr.t3", S3, 16'h0000, 16'h0002, 5'd0, 1'b1, 1'b0);
        exp_step("clr.t4", S4, 16'h0000, 16'h0004, 5'd3, 1'b1, 1'b0);
        #2;
        clear = 1'b0;
        #1;
        check_outs("clr.async", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        #2;
        clear = 1'b1;
        exp_step("clr.idle0", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        exp_step("clr.idle1", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

        // start pulsed during T3 is ignored
        bus_in = mk(5'b00011, 4'd7, 4'd4, 4'd3);
        start  = 1'b1;
        exp_step("ign.t0", S0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        start  = 1'b0;
        exp_step("ign.t1", S1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("ign.t2", S2, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("ign.t3", S3, 16'h0000, 16'h0010, 5'd0, 1'b1, 1'b0);
        start  = 1'b1;
        exp_step("ign.t4", S4, 16'h0000, 16'h0008, 5'd3, 1'b1, 1'b0);
        start  = 1'b0;
        exp_step("ign.t5", S5, 16'h0080, 16'h0000, 5'd0, 1'b1, 1'b1);
        exp_step("ign.end0", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        exp_step("ign.end1", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

        // start held high: one IDLE cycle between done and the next T0
        start = 1'b1;
        exp_step("bb.t0", S0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("bb.t1", S1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("bb.t2", S2, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("bb.t3", S3, 16'h0000, 16'h0010, 5'd0, 1'b1, 1'b0);
        exp_step("bb.t4", S4, 16'h0000, 16'h0008, 5'd3, 1'b1, 1'b0);
        exp_step("bb.t5", S5, 16'h0080, 16'h0000, 5'd0, 1'b1, 1'b1);
        exp_step("bb.gap", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        exp_step("bb.t0b", S0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        start = 1'b0;

        // Second instruction writes R0: result depends on the R0 read-only build option
        bus_in = mk(5'b00011, 4'd0, 4'd1, 4'd2);
        exp_step("r0.t1", S1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("r0.t2", S2, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0);
        exp_step("r0.t3", S3, 16'h0000, 16'h0002, 5'd0, 1'b1, 1'b0);
        exp_step("r0.t4", S4, 16'h0000, 16'h0004, 5'd3, 1'b1, 1'b0);
        exp_step("r0.t5", S5, R0_WR, 16'h0000, 5'd0, 1'b1, 1'b1);
        exp_step("r0.end", 14'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
